// File: rtl/mux4_rr_sequencer_if.sv
// Bundle of the request, mux-sample and result-handshake signals around the 4x1 mux sequencer.
// The sequencer takes the slave view; the producer/consumer side takes the master view.
interface mux4_rr_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [WIDTH-1:0] mux_out;
    logic             ready_in;
    logic             s0;
    logic             s1;
    logic [3:0]       grant;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_ch;
    logic             out_valid;

    modport slave (
        input  req, mux_out, ready_in,
        output s0, s1, grant, out_data, out_ch, out_valid
    );

    modport master (
        output req, mux_out, ready_in,
        input  s0, s1, grant, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux4_rr_sequencer.sv
// Round-robin sequencer that drives the 4x1 mux selects, waits for the mux to settle,
// and hands the captured value downstream through a registered valid/ready stage.
module mux4_rr_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux4_rr_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       ch_q, ch_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       out_ch_q, out_ch_d;
    logic             valid_q, valid_d;
    logic [2:0]       pick_s;

    // Returns {found, index}: first set request at or after (last+1) mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s = rr_pick(bus.req, last_q);

    // Next-state and output-register logic for the IDLE/SETTLE/HOLD sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        last_d   = last_q;
        sel_d    = sel_q;
        grant_d  = 4'b0000;
        data_d   = data_q;
        out_ch_d = out_ch_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[2]) begin
                    sel_d   = pick_s[1:0];
                    ch_d    = pick_s[1:0];
                    cnt_d   = SETTLE_CNT;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d   = bus.mux_out;
                    out_ch_d = ch_q;
                    valid_d  = 1'b1;
                    grant_d  = 4'b0001 << ch_q;
                    last_d   = ch_q;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Handshake only sees out_valid from the previous edge, so ready on the capture edge is ignored.
                if (valid_q && bus.ready_in) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ch_q     <= 2'd0;
            last_q   <= 2'd3;
            sel_q    <= 2'd0;
            grant_q  <= 4'b0000;
            data_q   <= '0;
            out_ch_q <= 2'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            out_ch_q <= out_ch_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.s0        = sel_q[0];
    assign bus.s1        = sel_q[1];
    assign bus.grant     = grant_q;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// Randomised and directed checks of the round-robin mux sequencer against a simple arbitration model.
module tb_mux4_rr_sequencer;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 1;

    logic clk;
    logic rst_n;
    logic [WIDTH-1:0] data_in [4];

    int tests_run;
    int tests_failed;
    int model_last;

    mux4_rr_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mux4_rr_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mux_out = data_in[{bus.s1, bus.s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick(input logic [3:0] req, input int last);
        int c;
        for (int k = 1; k <= 4; k++) begin
            c = (last + k) % 4;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < max_cycles && !ok) begin
            step();
            cycles++;
            if (bus.out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic set_bench_data();
        data_in[0] = 4'b0010;
        data_in[1] = 4'b1001;
        data_in[2] = 4'b1110;
        data_in[3] = 4'b0011;
    endtask

    task automatic test_single();
        int cyc;
        bit ok;
        bus.req = 4'b0100;
        step();
        tests_run++;
        if ({bus.s1, bus.s0} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_sel: got %b expected 10", {bus.s1, bus.s0});
        end
        wait_valid(10, cyc, ok);
        tests_run++;
        if (!ok || cyc != SETTLE + 1) begin
            tests_failed++;
            $display("FAIL single_latency: got ok=%0d edges=%0d expected edges=%0d", ok, cyc + 1, SETTLE + 2);
        end
        tests_run++;
        if (bus.out_data !== 4'b1110 || bus.out_ch !== 2'd2 || bus.grant !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_capture: got data=%b ch=%0d grant=%b expected 1110 2 0100",
                     bus.out_data, bus.out_ch, bus.grant);
        end
        model_last = 2;
        bus.req = 4'b0000;
        step();
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pulse_end: got grant=%b valid=%b expected 0000 0", bus.grant, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        bus.req = 4'b0000;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 3;
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if ({bus.s1, bus.s0, bus.grant, bus.out_data, bus.out_ch, bus.out_valid} !== 13'd0) begin
                tests_failed++;
                $display("FAIL reset_idle[%0d]: got s=%b grant=%b data=%b ch=%0d valid=%b expected all 0",
                         i, {bus.s1, bus.s0}, bus.grant, bus.out_data, bus.out_ch, bus.out_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        bit ok;
        int exp;
        bus.ready_in = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp = model_pick(4'b1111, model_last);
            wait_valid(20, cyc, ok);
            tests_run++;
            if (!ok || cyc != SETTLE + 2 || bus.out_ch !== 2'(exp) || bus.out_data !== data_in[exp] ||
                bus.grant !== (4'b0001 << exp)) begin
                tests_failed++;
                $display("FAIL rr[%0d]: got ok=%0d cyc=%0d ch=%0d data=%b grant=%b expected ch=%0d data=%b cyc=%0d",
                         i, ok, cyc, bus.out_ch, bus.out_data, bus.grant, exp, data_in[exp], SETTLE + 2);
            end
            model_last = exp;
            step();
            tests_run++;
            if (bus.grant !== 4'b0000 || bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_pulse[%0d]: got grant=%b valid=%b expected 0000 0", i, bus.grant, bus.out_valid);
            end
        end
        bus.req = 4'b0000;
        repeat (4) step();
        model_last = 0;
    endtask

    task automatic test_backpressure();
        int cyc;
        bit ok;
        bus.ready_in = 1'b0;
        bus.req = 4'b0010;
        wait_valid(20, cyc, ok);
        tests_run++;
        if (!ok || bus.out_data !== 4'b1001 || bus.out_ch !== 2'd1) begin
            tests_failed++;
            $display("FAIL bp_capture: got ok=%0d data=%b ch=%0d expected 1001 1", ok, bus.out_data, bus.out_ch);
        end
        model_last = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b1001 || {bus.s1, bus.s0} !== 2'b01 ||
                bus.grant !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%b s=%b grant=%b expected 1 1001 01 0000",
                         i, bus.out_valid, bus.out_data, {bus.s1, bus.s0}, bus.grant);
            end
        end
        bus.ready_in = 1'b1;
        bus.req = 4'b0000;
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: got valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_wrap_withdraw();
        int cyc;
        bit ok;
        bus.ready_in = 1'b1;
        bus.req = 4'b1000;
        wait_valid(20, cyc, ok);
        tests_run++;
        if (!ok || bus.out_ch !== 2'd3 || bus.out_data !== 4'b0011) begin
            tests_failed++;
            $display("FAIL wrap_d: got ok=%0d ch=%0d data=%b expected 3 0011", ok, bus.out_ch, bus.out_data);
        end
        model_last = 3;
        bus.req = 4'b1001;
        step();
        step();
        tests_run++;
        if ({bus.s1, bus.s0} !== 2'(model_pick(4'b1001, model_last))) begin
            tests_failed++;
            $display("FAIL wrap_sel: got %b expected %0d", {bus.s1, bus.s0}, model_pick(4'b1001, model_last));
        end
        bus.req = 4'b0000;
        wait_valid(20, cyc, ok);
        tests_run++;
        if (!ok || bus.out_ch !== 2'd0 || bus.out_data !== 4'b0010 || bus.grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL withdraw: got ok=%0d ch=%0d data=%b grant=%b expected 0 0010 0001",
                     ok, bus.out_ch, bus.out_data, bus.grant);
        end
        model_last = 0;
        step();
    endtask

    task automatic test_async_reset_hold();
        int cyc;
        bit ok;
        bus.ready_in = 1'b0;
        bus.req = 4'b0100;
        wait_valid(20, cyc, ok);
        bus.req = 4'b0000;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL arst_setup: got no out_valid expected out_valid=1");
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.grant !== 4'b0000 || bus.s0 !== 1'b0 || bus.s1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_immediate: got valid=%b grant=%b s=%b expected 0 0000 00",
                     bus.out_valid, bus.grant, {bus.s1, bus.s0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 3;
        bus.ready_in = 1'b1;
        bus.req = 4'b1111;
        wait_valid(20, cyc, ok);
        tests_run++;
        if (!ok || bus.out_ch !== 2'(model_pick(4'b1111, model_last)) || bus.grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL arst_first_grant: got ok=%0d ch=%0d grant=%b expected 0 0001", ok, bus.out_ch, bus.grant);
        end
        model_last = 0;
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_random();
        int cyc;
        bit ok;
        int exp;
        int hold;
        logic [3:0] req_cur;
        logic [WIDTH-1:0] cap;
        bus.ready_in = 1'b1;
        req_cur = 4'($urandom_range(1, 15));
        bus.req = req_cur;
        for (int t = 0; t < 30; t++) begin
            exp = model_pick(req_cur, model_last);
            cap = data_in[exp];
            wait_valid(30, cyc, ok);
            tests_run++;
            if (!ok || bus.out_ch !== 2'(exp) || bus.out_data !== cap || bus.grant !== (4'b0001 << exp)) begin
                tests_failed++;
                $display("FAIL rand[%0d]: req=%b got ok=%0d ch=%0d data=%b grant=%b expected ch=%0d data=%b",
                         t, req_cur, ok, bus.out_ch, bus.out_data, bus.grant, exp, cap);
            end
            model_last = exp;
            for (int k = 0; k < 4; k++) data_in[k] = 4'($urandom_range(0, 15));
            bus.ready_in = 1'b0;
            bus.req = 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                step();
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== cap || bus.out_ch !== 2'(exp)) begin
                    tests_failed++;
                    $display("FAIL rand_hold[%0d]: got valid=%b data=%b ch=%0d expected 1 %b %0d",
                             t, bus.out_valid, bus.out_data, bus.out_ch, cap, exp);
                end
            end
            req_cur = (t == 29) ? 4'b0000 : 4'($urandom_range(1, 15));
            bus.req = req_cur;
            bus.ready_in = 1'b1;
            step();
            tests_run++;
            if (bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_release[%0d]: got valid=%b expected 0", t, bus.out_valid);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        model_last = 3;
        set_bench_data();
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.ready_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_single();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap_withdraw();
        test_async_reset_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
